instr_dispatch: RTL

Upstream issue stage for the dual compute-unit chip top (comp0/comp1). Accepts 16-bit instructions over a valid/ready handshake and buffers them in a small FIFO. Decodes the target-unit field and issues each instruction in order to compute unit 0, compute unit 1, or both (broadcast). Its registered per-unit outputs drive the compute units' instruction inputs.

---
 rtl/instr_pkg.sv | 30 +++
 rtl/instr_fifo.sv | 59 +++++
 rtl/instr_dispatch.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/instr_pkg.sv
// Shared instruction-format definitions for the dispatch stage.
// Field positions, opcodes and the dispatcher FSM state type.
package instr_pkg;

    localparam int INSTR_W  = 16;
    localparam int UNIT_BIT = 15;
    localparam int OP_MSB   = 14;
    localparam int OP_LSB   = 12;
    localparam int REG_MSB  = 11;
    localparam int REG_LSB  = 8;

    typedef logic [INSTR_W-1:0] instr_t;
    typedef logic [2:0]         opcode_t;

    localparam opcode_t OP_NOP   = 3'b000;
    localparam opcode_t OP_LOAD  = 3'b001;
    localparam opcode_t OP_ADD   = 3'b010;
    localparam opcode_t OP_BCAST = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_BCAST
    } disp_state_e;

    function automatic logic is_bcast(input instr_t i);
        return i[OP_MSB:OP_LSB] == OP_BCAST;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Small synchronous instruction FIFO with occupancy counter.
// full/empty derive from the count only, so full never passes through.
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int IW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [IW-1:0] data_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [IW-1:0] head_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [IW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [CW-1:0] cnt_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = cnt_q == CW'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign do_push = push_i & !full_o;
    assign do_pop  = pop_i & !empty_o;
    assign head_o  = mem_q[rptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/instr_dispatch.sv
// In-order issue of buffered instructions to compute unit 0, 1 or both.
// Define INSTR_DISPATCH_STATS_EN to add per-unit issue counters.
module instr_dispatch
    import instr_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [IW-1:0] in_instr,
    output logic          in_ready,
    output logic          u0_valid,
    output logic [IW-1:0] u0_instr,
    input  logic          u0_ready,
    output logic          u1_valid,
    output logic [IW-1:0] u1_instr,
    input  logic          u1_ready,
    output logic          busy
`ifdef INSTR_DISPATCH_STATS_EN
    ,
    output logic [7:0]    u0_issued,
    output logic [7:0]    u1_issued
`endif
);
    disp_state_e state_q;
    logic        u0_valid_q;
    logic        u1_valid_q;
    instr_t      u0_instr_q;
    instr_t      u1_instr_q;
    logic        u0_acc_q;
    logic        u1_acc_q;

    logic        full;
    logic        empty;
    instr_t      head;
    logic        acc0;
    logic        acc1;
    logic        can_issue;
    logic        pop;
    logic        head_bc;
    logic        to_u0;
    logic        to_u1;

    instr_fifo #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (in_valid),
        .pop_i   (pop),
        .data_i  (in_instr),
        .full_o  (full),
        .empty_o (empty),
        .head_o  (head)
    );

    assign acc0    = u0_valid_q & u0_ready;
    assign acc1    = u1_valid_q & u1_ready;
    assign head_bc = is_bcast(head);
    assign to_u0   = head_bc | !head[UNIT_BIT];
    assign to_u1   = head_bc | head[UNIT_BIT];

    always_comb begin
        can_issue = 1'b0;
        unique case (state_q)
            ST_IDLE:  can_issue = 1'b1;
            ST_ISSUE: can_issue = acc0 | acc1;
            ST_BCAST: can_issue = (u0_acc_q | acc0) & (u1_acc_q | acc1);
            default:  can_issue = 1'b0;
        endcase
        pop = can_issue & !empty;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            u0_valid_q <= 1'b0;
            u1_valid_q <= 1'b0;
            u0_instr_q <= '0;
            u1_instr_q <= '0;
            u0_acc_q   <= 1'b0;
            u1_acc_q   <= 1'b0;
        end else begin
            if (acc0) begin
                u0_valid_q <= 1'b0;
            end
            if (acc1) begin
                u1_valid_q <= 1'b0;
            end
            if (state_q == ST_BCAST) begin
                if (acc0) u0_acc_q <= 1'b1;
                if (acc1) u1_acc_q <= 1'b1;
            end
            // Loads below override the clears above on back-to-back issue.
            if (can_issue) begin
                u0_acc_q <= 1'b0;
                u1_acc_q <= 1'b0;
                if (pop) begin
                    if (to_u0) begin
                        u0_valid_q <= 1'b1;
                        u0_instr_q <= head;
                    end
                    if (to_u1) begin
                        u1_valid_q <= 1'b1;
                        u1_instr_q <= head;
                    end
                    state_q <= head_bc ? ST_BCAST : ST_ISSUE;
                end else begin
                    state_q <= ST_IDLE;
                end
            end
        end
    end

`ifdef INSTR_DISPATCH_STATS_EN
    logic [7:0] u0_cnt_q;
    logic [7:0] u1_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            u0_cnt_q <= '0;
            u1_cnt_q <= '0;
        end else begin
            if (acc0) u0_cnt_q <= u0_cnt_q + 8'd1;
            if (acc1) u1_cnt_q <= u1_cnt_q + 8'd1;
        end
    end

    assign u0_issued = u0_cnt_q;
    assign u1_issued = u1_cnt_q;
`endif

    assign in_ready = !full;
    assign u0_valid = u0_valid_q;
    assign u1_valid = u1_valid_q;
    assign u0_instr = u0_instr_q;
    assign u1_instr = u1_instr_q;
    assign busy     = !empty | u0_valid_q | u1_valid_q;

endmodule
